// File: rtl/bp_fpga_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_fpga_host_pkg
//  Description : Shared types for the BlackParrot FPGA host arbiter: the
//                arbiter FSM states, the host command record and the
//                requester id constants (NBF loader, debug host).
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_fpga_host_pkg;

    // Widest address/data the command record carries; narrower instances
    // zero-extend into it and truncate back out.
    localparam int C_HOST_ADDR_MAX_W = 64;
    localparam int C_HOST_DATA_MAX_W = 64;

    // Requester ids
    localparam logic C_ID_NBF   = 1'b0;
    localparam logic C_ID_DEBUG = 1'b1;

    typedef enum logic [0:0] {
        e_arb   = 1'b0,
        e_fence = 1'b1
    } host_state_e;

    typedef struct packed {
        logic                         fence;
        logic                         w;
        logic [2:0]                   size;
        logic [C_HOST_ADDR_MAX_W-1:0] addr;
        logic [C_HOST_DATA_MAX_W-1:0] data;
    } host_cmd_s;

endpackage
`default_nettype wire

// File: rtl/bsg_fifo_1r1w_small.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_fifo_1r1w_small
//  Description : Small flop-based FIFO, one write / one read port,
//                valid/ready on the write side, valid/yumi on the read side.
//                els_p must be a power of two, at least 2.
//  Ports       : clk_i, reset_i (async, active-high)
//                v_i/ready_o/data_i   - push side
//                v_o/data_o/yumi_i    - pop side (data_o is the head)
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_fifo_1r1w_small #(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int PTR_W = $clog2(els_p);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]       wptr_q, wptr_d;
    logic [PTR_W:0]       rptr_q, rptr_d;
    logic [width_p-1:0]   mem_q [els_p];
    logic                 w_push;
    logic                 w_pop;

    always_comb begin
        ready_o = !((wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                    (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]));
        v_o     = (wptr_q != rptr_q);
        data_o  = mem_q[rptr_q[PTR_W-1:0]];
        w_push  = v_i & ready_o;
        w_pop   = yumi_i & v_o;
        wptr_d  = w_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = w_pop  ? rptr_q + 1'b1 : rptr_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: nothing is read until a push has written it.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wptr_q[PTR_W-1:0]] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/blackparrot_fpga_host_arb.sv
`default_nettype none
// ============================================================================
//  Module      : blackparrot_fpga_host_arb
//  Description : Round-robin arbiter between the NBF loader (id 0) and the
//                debug host (id 1) in front of bp_me_fifo_to_axi. Tracks
//                outstanding AXI writes, routes read responses back by
//                request order, and implements fences that drain writes.
//  Ports       : req_*      - per-requester command inputs, req_ready_and_o
//                resp_*     - per-requester read responses (shared data)
//                cmd_*      - forwarded command to bp_me_fifo_to_axi
//                rd_*       - read response from bp_me_fifo_to_axi
//                wr_done_i  - one pulse per AXI write completion
//                wr_count_o - outstanding writes, error_o - sticky error
//  Revision    : 1.0 - initial release
// ============================================================================
module blackparrot_fpga_host_arb
    import bp_fpga_host_pkg::*;
#(
    parameter int addr_width_p = 64,
    parameter int data_width_p = 64,
    parameter int max_writes_p = 8,
    parameter int max_reads_p  = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [1:0]                         req_v_i,
    input  logic [1:0]                         req_fence_i,
    input  logic [1:0]                         req_w_i,
    input  logic [2*addr_width_p-1:0]          req_addr_i,
    input  logic [2*data_width_p-1:0]          req_data_i,
    input  logic [5:0]                         req_size_i,
    output logic [1:0]                         req_ready_and_o,
    output logic [1:0]                         resp_v_o,
    output logic [data_width_p-1:0]            resp_data_o,
    input  logic [1:0]                         resp_ready_and_i,
    output logic                               cmd_v_o,
    output logic                               cmd_w_o,
    output logic [addr_width_p-1:0]            cmd_addr_o,
    output logic [data_width_p-1:0]            cmd_data_o,
    output logic [2:0]                         cmd_size_o,
    input  logic                               cmd_ready_and_i,
    input  logic                               rd_v_i,
    input  logic [data_width_p-1:0]            rd_data_i,
    output logic                               rd_ready_and_o,
    input  logic                               wr_done_i,
    output logic [$clog2(max_writes_p+1)-1:0]  wr_count_o,
    output logic                               error_o
);

    localparam int                  WR_CNT_W     = $clog2(max_writes_p+1);
    localparam logic [WR_CNT_W-1:0] C_MAX_WRITES = WR_CNT_W'(max_writes_p);

    host_state_e          state_q, state_d;
    logic                 fence_id_q, fence_id_d;
    logic                 prio_q, prio_d;
    logic [WR_CNT_W-1:0]  wr_count_q, wr_count_d;
    logic                 error_q, error_d;

    host_cmd_s [1:0]      w_req;
    host_cmd_s            w_sel;
    logic [1:0]           w_elig;
    logic                 w_grant;
    logic                 w_credit_ok;
    logic                 w_cmd_fire;
    logic                 w_fence_hit;
    logic                 w_fence_ack;
    logic                 w_ack_id;
    logic                 w_fifo_ready;
    logic                 w_fifo_v;
    logic                 w_fifo_head;
    logic                 w_fifo_push;
    logic                 w_fifo_pop;

    assign w_credit_ok = (wr_count_q < C_MAX_WRITES);

    for (genvar i = 0; i < 2; i++) begin : g_req
        localparam logic C_ID = 1'(i);

        assign w_req[i] = '{
            fence: req_fence_i[i],
            w:     req_w_i[i],
            size:  req_size_i[3*i +: 3],
            addr:  C_HOST_ADDR_MAX_W'(req_addr_i[addr_width_p*i +: addr_width_p]),
            data:  C_HOST_DATA_MAX_W'(req_data_i[data_width_p*i +: data_width_p])
        };

        // While fencing, the fencing requester is frozen and the other side
        // may only issue reads (no writes, no second fence).
        assign w_elig[i] = req_v_i[i] &
            ((state_q == e_fence)
                ? ((C_ID != fence_id_q) & ~w_req[i].fence & ~w_req[i].w & w_fifo_ready)
                : (w_req[i].fence | (w_req[i].w ? w_credit_ok : w_fifo_ready)));
    end

    // Priority holder wins if eligible; otherwise the other side takes the
    // grant so an ineligible head never blocks the other requester.
    assign w_grant = w_elig[prio_q] ? prio_q : (w_elig[~prio_q] ? ~prio_q : prio_q);

    always_comb begin
        state_d         = state_q;
        fence_id_d      = fence_id_q;
        prio_d          = prio_q;
        wr_count_d      = wr_count_q;
        error_d         = error_q;
        req_ready_and_o = '0;
        resp_v_o        = '0;
        rd_ready_and_o  = 1'b0;
        w_fifo_pop      = 1'b0;
        w_fence_ack     = 1'b0;
        w_ack_id        = w_grant;

        w_sel       = w_req[w_grant];
        cmd_v_o     = ~reset_i & w_elig[w_grant] & ~w_sel.fence;
        w_cmd_fire  = cmd_v_o & cmd_ready_and_i;
        w_fence_hit = ~reset_i & w_elig[w_grant] & w_sel.fence;
        w_fifo_push = w_cmd_fire & ~w_sel.w;

        if (w_cmd_fire) begin
            req_ready_and_o[w_grant] = 1'b1;
        end

        case (state_q)
            e_arb: begin
                if (w_fence_hit) begin
                    if (wr_count_q == '0) begin
                        req_ready_and_o[w_grant] = 1'b1;
                        w_fence_ack              = 1'b1;
                    end else begin
                        state_d    = e_fence;
                        fence_id_d = w_grant;
                    end
                end
            end
            e_fence: begin
                if (!reset_i && (wr_count_q == '0)) begin
                    req_ready_and_o[fence_id_q] = 1'b1;
                    w_fence_ack                 = 1'b1;
                    w_ack_id                    = fence_id_q;
                    state_d                     = e_arb;
                end
            end
            default: state_d = e_arb;
        endcase

        if (w_cmd_fire) begin
            prio_d = ~w_grant;
        end else if (w_fence_ack) begin
            prio_d = ~w_ack_id;
        end

        // Write credits: simultaneous issue and completion cancel out.
        if (w_cmd_fire && w_sel.w && !wr_done_i) begin
            wr_count_d = wr_count_q + 1'b1;
        end else if (!(w_cmd_fire && w_sel.w) && wr_done_i) begin
            if (wr_count_q == '0) begin
                error_d = 1'b1;
            end else begin
                wr_count_d = wr_count_q - 1'b1;
            end
        end

        // Responses return in issue order; the FIFO head names the owner.
        // With nothing outstanding the response is sunk and flagged.
        if (!reset_i) begin
            if (w_fifo_v) begin
                resp_v_o[w_fifo_head] = rd_v_i;
                rd_ready_and_o        = resp_ready_and_i[w_fifo_head];
                w_fifo_pop            = rd_v_i & resp_ready_and_i[w_fifo_head];
            end else begin
                rd_ready_and_o = 1'b1;
                if (rd_v_i) begin
                    error_d = 1'b1;
                end
            end
        end
    end

    assign cmd_w_o     = w_sel.w;
    assign cmd_addr_o  = addr_width_p'(w_sel.addr);
    assign cmd_data_o  = data_width_p'(w_sel.data);
    assign cmd_size_o  = w_sel.size;
    assign resp_data_o = rd_data_i;
    assign wr_count_o  = wr_count_q;
    assign error_o     = error_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_arb;
            fence_id_q <= C_ID_NBF;
            prio_q     <= C_ID_NBF;
            wr_count_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fence_id_q <= fence_id_d;
            prio_q     <= prio_d;
            wr_count_q <= wr_count_d;
            error_q    <= error_d;
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p (1),
        .els_p   (max_reads_p)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (w_fifo_push),
        .ready_o (w_fifo_ready),
        .data_i  (w_grant),
        .v_o     (w_fifo_v),
        .data_o  (w_fifo_head),
        .yumi_i  (w_fifo_pop)
    );

endmodule
`default_nettype wire

// File: tb/tb_blackparrot_fpga_host_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blackparrot_fpga_host_arb
//  Description : Self-checking bench for blackparrot_fpga_host_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_blackparrot_fpga_host_arb;

    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req_v, req_fence, req_w, req_ready, resp_v, resp_ready;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_data;
    logic [5:0]      req_size;
    logic [DW-1:0]   resp_data, cmd_data, rd_data;
    logic            cmd_v, cmd_w, cmd_ready, rd_v, rd_ready, wr_done, error;
    logic [AW-1:0]   cmd_addr;
    logic [2:0]      cmd_size;
    logic [3:0]      wr_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } resp_t;

    resp_t resp_q[$];
    logic  grant_q[$];

    always #5 clk = ~clk;

    blackparrot_fpga_host_arb #(
        .addr_width_p (AW),
        .data_width_p (DW),
        .max_writes_p (8),
        .max_reads_p  (4)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .req_v_i          (req_v),
        .req_fence_i      (req_fence),
        .req_w_i          (req_w),
        .req_addr_i       (req_addr),
        .req_data_i       (req_data),
        .req_size_i       (req_size),
        .req_ready_and_o  (req_ready),
        .resp_v_o         (resp_v),
        .resp_data_o      (resp_data),
        .resp_ready_and_i (resp_ready),
        .cmd_v_o          (cmd_v),
        .cmd_w_o          (cmd_w),
        .cmd_addr_o       (cmd_addr),
        .cmd_data_o       (cmd_data),
        .cmd_size_o       (cmd_size),
        .cmd_ready_and_i  (cmd_ready),
        .rd_v_i           (rd_v),
        .rd_data_i        (rd_data),
        .rd_ready_and_o   (rd_ready),
        .wr_done_i        (wr_done),
        .wr_count_o       (wr_count),
        .error_o          (error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_v      = '0;
        req_fence  = '0;
        req_w      = '0;
        req_addr   = '0;
        req_data   = '0;
        req_size   = 6'b011_011;
        resp_ready = '0;
        cmd_ready  = 1'b0;
        rd_v       = 1'b0;
        rd_data    = '0;
        wr_done    = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        req_v = 2'b11; cmd_ready = 1'b1; rd_v = 1'b1; resp_ready = 2'b11;
        #3;
        total_cnt++; if (req_ready !== 2'b00) $display("FAIL rst_ready got=%b exp=00", req_ready); else pass_cnt++;
        total_cnt++; if (cmd_v !== 1'b0) $display("FAIL rst_cmd_v got=%b exp=0", cmd_v); else pass_cnt++;
        total_cnt++; if (resp_v !== 2'b00) $display("FAIL rst_resp_v got=%b exp=00", resp_v); else pass_cnt++;
        total_cnt++; if (wr_count !== 4'd0) $display("FAIL rst_wr_count got=%0d exp=0", wr_count); else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL rst_error got=%b exp=0", error); else pass_cnt++;
        apply_reset();
    endtask

    task automatic test_round_robin();
        logic g;
        apply_reset();
        for (int k = 0; k < 8; k++) grant_q.push_back(k[0]);
        req_v = 2'b11; req_w = 2'b11; cmd_ready = 1'b1;
        req_addr = {64'h0000_0000_1000_0100, 64'h0000_0000_1000_0000};
        for (int k = 0; k < 10; k++) begin
            #1;
            if (grant_q.size() > 0) begin
                g = grant_q.pop_front();
                total_cnt++; if (req_ready !== (g ? 2'b10 : 2'b01)) $display("FAIL rr_grant k=%0d got=%b exp_id=%0d", k, req_ready, g); else pass_cnt++;
                total_cnt++; if (cmd_addr !== (g ? 64'h1000_0100 : 64'h1000_0000)) $display("FAIL rr_addr k=%0d got=%h", k, cmd_addr); else pass_cnt++;
                total_cnt++; if (wr_count !== 4'(k)) $display("FAIL rr_count k=%0d got=%0d exp=%0d", k, wr_count, k); else pass_cnt++;
            end else begin
                total_cnt++; if ({cmd_v, req_ready} !== 3'b000) $display("FAIL rr_full k=%0d got=%b exp=000", k, {cmd_v, req_ready}); else pass_cnt++;
                total_cnt++; if (wr_count !== 4'd8) $display("FAIL rr_count_sat got=%0d exp=8", wr_count); else pass_cnt++;
            end
            tick();
        end
        req_v = 2'b00;
    endtask

    task automatic test_credit_limit();
        apply_reset();
        req_v = 2'b01; req_w = 2'b01; cmd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            total_cnt++; if (req_ready !== 2'b01) $display("FAIL cr_accept k=%0d got=%b exp=01", k, req_ready); else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if ({cmd_v, req_ready} !== 3'b000) $display("FAIL cr_ninth_stall got=%b exp=000", {cmd_v, req_ready}); else pass_cnt++;
        wr_done = 1'b1;
        #1;
        total_cnt++; if (req_ready !== 2'b00) $display("FAIL cr_stall_on_done got=%b exp=00", req_ready); else pass_cnt++;
        tick();
        wr_done = 1'b0;
        #1;
        total_cnt++; if (wr_count !== 4'd7) $display("FAIL cr_after_done got=%0d exp=7", wr_count); else pass_cnt++;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL cr_ninth_accept got=%b exp=01", req_ready); else pass_cnt++;
        tick();
        req_v = 2'b00;
        #1;
        total_cnt++; if (wr_count !== 4'd8) $display("FAIL cr_final_count got=%0d exp=8", wr_count); else pass_cnt++;
    endtask

    task automatic test_read_routing();
        resp_t        exp;
        logic [DW-1:0] downstream [2];
        downstream[0] = 64'hAAAA;
        downstream[1] = 64'hBBBB;
        apply_reset();
        cmd_ready = 1'b1;
        req_addr  = {64'h0000_0000_8000_0000, 64'h0000_0000_8000_0008};
        req_v = 2'b10;
        resp_q.push_back('{id: 1'b1, data: 64'hAAAA});
        #1;
        total_cnt++; if ({req_ready, cmd_w} !== 3'b100) $display("FAIL rd_issue1 got=%b exp=100", {req_ready, cmd_w}); else pass_cnt++;
        total_cnt++; if (cmd_addr !== 64'h8000_0000) $display("FAIL rd_addr1 got=%h exp=80000000", cmd_addr); else pass_cnt++;
        tick();
        req_v = 2'b01;
        resp_q.push_back('{id: 1'b0, data: 64'hBBBB});
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL rd_issue0 got=%b exp=01", req_ready); else pass_cnt++;
        total_cnt++; if (cmd_addr !== 64'h8000_0008) $display("FAIL rd_addr0 got=%h exp=80000008", cmd_addr); else pass_cnt++;
        tick();
        req_v = 2'b00;
        rd_v = 1'b1; rd_data = downstream[0]; resp_ready = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            total_cnt++; if ({resp_v, rd_ready} !== {(resp_q[0].id ? 2'b10 : 2'b01), 1'b0}) $display("FAIL rd_hold k=%0d got=%b", k, {resp_v, rd_ready}); else pass_cnt++;
            tick();
        end
        resp_ready = 2'b11;
        for (int k = 0; k < 2; k++) begin
            rd_data = downstream[k];
            exp = resp_q.pop_front();
            #1;
            total_cnt++; if ({resp_v, rd_ready} !== {(exp.id ? 2'b10 : 2'b01), 1'b1}) $display("FAIL rd_route k=%0d got=%b exp_id=%0d", k, {resp_v, rd_ready}, exp.id); else pass_cnt++;
            total_cnt++; if (resp_data !== exp.data) $display("FAIL rd_data k=%0d got=%h exp=%h", k, resp_data, exp.data); else pass_cnt++;
            tick();
        end
        rd_v = 1'b0;
        #1;
        total_cnt++; if ({resp_v, error} !== 3'b000) $display("FAIL rd_idle got=%b exp=000", {resp_v, error}); else pass_cnt++;
        rd_v = 1'b1;
        #1;
        total_cnt++; if ({resp_v, rd_ready} !== 3'b001) $display("FAIL rd_sink got=%b exp=001", {resp_v, rd_ready}); else pass_cnt++;
        tick();
        rd_v = 1'b0;
        #1;
        total_cnt++; if (error !== 1'b1) $display("FAIL rd_empty_error got=%b exp=1", error); else pass_cnt++;
    endtask

    task automatic test_fifo_full();
        apply_reset();
        cmd_ready = 1'b1;
        req_v = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            total_cnt++; if (req_ready !== 2'b01) $display("FAIL ff_read0 k=%0d got=%b exp=01", k, req_ready); else pass_cnt++;
            tick();
        end
        req_v = 2'b10;
        #1;
        total_cnt++; if (req_ready !== 2'b10) $display("FAIL ff_read1 got=%b exp=10", req_ready); else pass_cnt++;
        tick();
        req_v = 2'b01;
        #1;
        total_cnt++; if ({cmd_v, req_ready} !== 3'b000) $display("FAIL ff_full_stall got=%b exp=000", {cmd_v, req_ready}); else pass_cnt++;
        req_v = 2'b11; req_w = 2'b10;
        #1;
        total_cnt++; if ({req_ready, cmd_w} !== 3'b101) $display("FAIL ff_no_hol got=%b exp=101", {req_ready, cmd_w}); else pass_cnt++;
        tick();
        req_v = 2'b00;
    endtask

    task automatic test_fence();
        apply_reset();
        cmd_ready = 1'b1;
        req_v = 2'b01; req_w = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            total_cnt++; if (req_ready !== 2'b01) $display("FAIL fn_write k=%0d got=%b exp=01", k, req_ready); else pass_cnt++;
            tick();
        end
        req_w = 2'b00; req_fence = 2'b01;
        #1;
        total_cnt++; if ({cmd_v, req_ready} !== 3'b000) $display("FAIL fn_wait got=%b exp=000", {cmd_v, req_ready}); else pass_cnt++;
        tick();
        req_v = 2'b11; req_w = 2'b10;
        #1;
        total_cnt++; if ({cmd_v, req_ready} !== 3'b000) $display("FAIL fn_w1_stall got=%b exp=000", {cmd_v, req_ready}); else pass_cnt++;
        tick();
        req_w = 2'b00;
        #1;
        total_cnt++; if ({cmd_v, cmd_w, req_ready} !== 4'b1010) $display("FAIL fn_r1_fwd got=%b exp=1010", {cmd_v, cmd_w, req_ready}); else pass_cnt++;
        tick();
        req_w = 2'b10; wr_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total_cnt++; if (req_ready !== 2'b00) $display("FAIL fn_early_ack k=%0d got=%b exp=00", k, req_ready); else pass_cnt++;
            tick();
        end
        wr_done = 1'b0;
        #1;
        total_cnt++; if ({cmd_v, req_ready} !== 3'b001) $display("FAIL fn_ack got=%b exp=001", {cmd_v, req_ready}); else pass_cnt++;
        total_cnt++; if (wr_count !== 4'd0) $display("FAIL fn_drained got=%0d exp=0", wr_count); else pass_cnt++;
        tick();
        req_v = 2'b10; req_fence = 2'b00;
        #1;
        total_cnt++; if ({cmd_w, req_ready} !== 3'b110) $display("FAIL fn_resume got=%b exp=110", {cmd_w, req_ready}); else pass_cnt++;
        tick();
        req_v = 2'b00;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        cmd_ready = 1'b1;
        req_v = 2'b01; req_w = 2'b01;
        tick();
        wr_done = 1'b1;
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL sim_accept got=%b exp=01", req_ready); else pass_cnt++;
        tick();
        req_v = 2'b00;
        #1;
        total_cnt++; if (wr_count !== 4'd1) $display("FAIL sim_hold got=%0d exp=1", wr_count); else pass_cnt++;
        tick();
        wr_done = 1'b0;
        #1;
        total_cnt++; if ({wr_count, error} !== 5'b0000_0) $display("FAIL sim_drain got=%b exp=00000", {wr_count, error}); else pass_cnt++;
        req_v = 2'b01; req_w = 2'b00; req_fence = 2'b01;
        #1;
        total_cnt++; if ({cmd_v, req_ready} !== 3'b001) $display("FAIL sim_fence_now got=%b exp=001", {cmd_v, req_ready}); else pass_cnt++;
        tick();
        req_v = 2'b10; req_w = 2'b10; req_fence = 2'b00;
        #1;
        total_cnt++; if (req_ready !== 2'b10) $display("FAIL sim_stay_arb got=%b exp=10", req_ready); else pass_cnt++;
        tick();
        req_v = 2'b00; wr_done = 1'b1;
        tick();
        #1;
        total_cnt++; if ({wr_count, error} !== 5'b0000_0) $display("FAIL sim_zero got=%b exp=00000", {wr_count, error}); else pass_cnt++;
        tick();
        wr_done = 1'b0;
        #1;
        total_cnt++; if ({wr_count, error} !== 5'b0000_1) $display("FAIL sim_underflow got=%b exp=00001", {wr_count, error}); else pass_cnt++;
    endtask

    task automatic test_reset_mid_fence();
        apply_reset();
        cmd_ready = 1'b1;
        req_v = 2'b01; req_w = 2'b01;
        tick();
        req_w = 2'b00; req_fence = 2'b01;
        tick();
        rd_v = 1'b1;
        tick();
        rd_v = 1'b0;
        #1;
        total_cnt++; if (error !== 1'b1) $display("FAIL mr_pre_error got=%b exp=1", error); else pass_cnt++;
        req_v = 2'b11; rd_v = 1'b1; resp_ready = 2'b11;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++; if ({cmd_v, req_ready, resp_v, rd_ready} !== 6'b0) $display("FAIL mr_outputs got=%b exp=000000", {cmd_v, req_ready, resp_v, rd_ready}); else pass_cnt++;
        total_cnt++; if ({wr_count, error} !== 5'b0) $display("FAIL mr_state got=%b exp=00000", {wr_count, error}); else pass_cnt++;
        tick();
        reset = 1'b0;
        rd_v = 1'b0; req_v = 2'b10; req_fence = 2'b00; req_w = 2'b10;
        #1;
        total_cnt++; if (req_ready !== 2'b10) $display("FAIL mr_back_to_arb got=%b exp=10", req_ready); else pass_cnt++;
        tick();
        req_v = 2'b00;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_read_routing();
        test_fifo_full();
        test_fence();
        test_simultaneous();
        test_reset_mid_fence();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/blackparrot_fpga_host_arb.md
BLACKPARROT_FPGA_HOST_ARB -- requirements
Module: blackparrot_fpga_host_arb

Interface
REQ-001 Parameters SHALL be:
- addr_width_p, default 64: command address width.
- data_width_p, default 64: command and response data width.
- max_writes_p, default 8: maximum outstanding AXI writes.
- max_reads_p, default 4: maximum outstanding reads; power of 2.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1: the single clock.
- reset_i, in, 1: asynchronous, active-high reset.
- req_v_i, in, 2: command valid, one bit per requester; 0 = NBF loader, 1 = debug host.
- req_fence_i, in, 2: command is a fence, not forwarded.
- req_w_i, in, 2: 1 = write, 0 = read.
- req_addr_i, in, 2*addr_width_p: command address.
- req_data_i, in, 2*data_width_p: write data.
- req_size_i, in, 2*3: log2 byte size.
- req_ready_and_o, out, 2: command accepted.
- resp_v_o, out, 2: read response valid.
- resp_data_o, out, data_width_p: read data, shared by both requesters.
- resp_ready_and_i, in, 2: requester accepts response.
- cmd_v_o, out, 1: command valid to bp_me_fifo_to_axi.
- cmd_w_o, out, 1: write flag to bp_me_fifo_to_axi.
- cmd_addr_o, out, addr_width_p: address to bp_me_fifo_to_axi.
- cmd_data_o, out, data_width_p: data to bp_me_fifo_to_axi.
- cmd_size_o, out, 3: size to bp_me_fifo_to_axi.
- cmd_ready_and_i, in, 1: downstream accepts command.
- rd_v_i, in, 1: read response from bp_me_fifo_to_axi.
- rd_data_i, in, data_width_p: read response data.
- rd_ready_and_o, out, 1: read response accepted.
- wr_done_i, in, 1: one-cycle pulse per AXI B handshake.
- wr_count_o, out, clog2(max_writes_p+1): outstanding writes.
- error_o, out, 1: sticky protocol error.

Function
REQ-003 Arbitration SHALL be round-robin between the two requesters.
- A priority pointer SHALL toggle to the non-granted requester after each accepted command, fence included.

REQ-004 Exactly one requester SHALL be granted per cycle.
- cmd_* SHALL mux the granted requester's fields combinationally.
- cmd_v_o SHALL be req_v_i[g] & ~req_fence_i[g] & eligible.

REQ-005 Eligibility:
- A write SHALL be eligible only when wr_count_o < max_writes_p.
- A read SHALL be eligible only when the order FIFO is not full.
- An ineligible requester SHALL lose the grant to the other requester that cycle; no head-of-line blocking across requesters.

REQ-006 Commands SHALL be accepted on the same cycle as presented: req_ready_and_o[g] = cmd_v_o & cmd_ready_and_i. Zero added latency.

REQ-007 Write counter:
- SHALL increment on an accepted write.
- SHALL decrement on wr_done_i.
- SHALL hold when both occur in the same cycle.

REQ-008 wr_done_i with wr_count_o == 0:
- The counter SHALL stay at 0.
- error_o SHALL set.

REQ-009 Order FIFO: each accepted read SHALL push the granted requester id (1 bit) into a max_reads_p-deep FIFO.

REQ-010 Read response routing:
- resp_v_o[id] SHALL be rd_v_i for the head id; the other bit of resp_v_o SHALL be 0.
- rd_ready_and_o SHALL be resp_ready_and_i[head id].
- The FIFO SHALL pop on the rd handshake.

REQ-011 rd_v_i with an empty order FIFO:
- rd_ready_and_o SHALL be 1 (sink the response).
- error_o SHALL set.

REQ-012 FSM states: e_arb, e_fence.
- In e_arb, a granted fence SHALL move the FSM to e_fence and latch the fencing requester id.
- In e_fence, that requester SHALL be blocked.
- The other requester SHALL continue to issue reads only; its writes are blocked.
- When wr_count_o == 0, the fence SHALL be acked: req_ready_and_o[id] = 1 for one cycle, and the FSM returns to e_arb.
- A fence granted in e_arb with wr_count_o == 0 SHALL be acked in the same cycle and the FSM stays in e_arb.

REQ-013 A second fence while in e_fence SHALL wait until the FSM returns to e_arb.

REQ-014 Read/write ordering between requesters is not enforced beyond fences.

Reset
REQ-015 On reset_i, all state SHALL clear asynchronously:
- FSM to e_arb.
- Priority pointer to 0.
- wr_count_o to 0.
- Order FIFO empty.
- error_o to 0.

REQ-016 During reset, all req_ready_and_o, resp_v_o and cmd_v_o SHALL be 0.
- Reset mid-transaction discards outstanding credits and read ids; the system resets downstream together.

Structure
REQ-017 The package bp_fpga_host_pkg SHALL hold:
- the FSM state enum;
- the host command struct (fence, w, size, addr, data);
- the requester id constants (NBF = 0, DEBUG = 1).

REQ-018 The order FIFO SHALL be one sub-module instance, bsg_fifo_1r1w_small, width 1, els max_reads_p.
- The write counter and FSM SHALL be inline.

Verification
REQ-019 Round-robin: both requesters hold writes continuously, cmd_ready_and_i = 1 -> grants alternate 0,1,0,1; wr_count_o increments by 1 per cycle until it reaches 8.

REQ-020 Credit limit: 8 writes accepted, no wr_done_i -> 9th write stalls; one wr_done_i pulse -> 9th write is accepted the next cycle and wr_count_o remains 8.

REQ-021 Read routing: requester 1 reads 0x8000_0000, then requester 0 reads 0x8000_0008 -> responses 0xAAAA and 0xBBBB are delivered to resp_v_o[1], then resp_v_o[0], in that order.
- Hold resp_ready_and_i[1] = 0 for 3 cycles -> rd_ready_and_o stays 0 for those 3 cycles.

REQ-022 Fence:
- Requester 0 issues 3 writes, then a fence -> the fence ack is delayed until the third wr_done_i.
- Requester 1 reads issued during the fence are forwarded; requester 1 writes are stalled.

REQ-023 Simultaneous events and errors:
- An accepted write and wr_done_i in the same cycle -> wr_count_o unchanged.
- wr_done_i at count 0 -> error_o = 1 and count stays 0.
- Async reset_i mid-fence -> FSM returns to e_arb and all outputs are 0.
